// File: rtl/ie_collector.sv
// ie_collector: picks one exception/interrupt per service window and
// pulses IE with captured context. Optional: IE_DROP_COUNT_EN.
module ie_collector #(
  parameter int START_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        wb_valid,
  input  logic        wb_prot_fault,
  input  logic        wb_page_fault,
  input  logic [31:0] wb_EIP,
  input  logic [31:0] wb_next_EIP,
  input  logic [17:0] wb_EFLAGS,
  input  logic [15:0] wb_CS,
  input  logic        int_req,
  input  logic        is_servicing_IE,
  output logic        IE_out,
  output logic [2:0]  IE_type_out,
  output logic [31:0] EIP_out,
  output logic [17:0] EFLAGS_out,
  output logic [15:0] CS_out,
  output logic        busy,
`ifdef IE_DROP_COUNT_EN
  output logic [7:0]  drop_cnt,
`endif
  output logic        start_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PULSE,
    S_WAIT,
    S_BUSY
  } state_t;

  localparam logic [3:0] TO_LAST =
    4'(START_TIMEOUT - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic        int_pend;

  logic        prot_hit;
  logic        page_hit;
  logic        fault_hit;
  logic        int_hit;
  logic        issue;
  logic        issue_int;
  logic [2:0]  type_nxt;

  assign prot_hit  = wb_valid & wb_prot_fault;
  assign page_hit  = wb_valid & wb_page_fault;
  assign fault_hit = prot_hit | page_hit;
  assign int_hit   = wb_valid & (int_pend | int_req);
  assign issue     = (state == S_IDLE)
                   & (fault_hit | int_hit);
  assign issue_int = issue & ~fault_hit;

  // fixed-priority one-hot type select
  always_comb begin
    type_nxt = 3'b000;
    priority case (1'b1)
      prot_hit: type_nxt = 3'b001;
      page_hit: type_nxt = 3'b010;
      int_hit:  type_nxt = 3'b100;
      default:  type_nxt = 3'b000;
    endcase
  end

  // interrupt latch; consumed only when an interrupt issues
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      int_pend <= 1'b0;
    end else if (enable) begin
      if (issue_int)
        int_pend <= 1'b0;
      else if (int_req)
        int_pend <= 1'b1;
    end
  end

  // issue FSM with registered pulse, context and status
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      cnt         <= 4'd0;
      IE_out      <= 1'b0;
      IE_type_out <= 3'b000;
      EIP_out     <= 32'd0;
      EFLAGS_out  <= 18'd0;
      CS_out      <= 16'd0;
      busy        <= 1'b0;
      start_err   <= 1'b0;
    end else if (enable) begin
      unique case (state)
        S_IDLE: begin
          if (issue) begin
            state       <= S_PULSE;
            IE_out      <= 1'b1;
            busy        <= 1'b1;
            IE_type_out <= type_nxt;
            EIP_out     <= issue_int
                         ? wb_next_EIP
                         : wb_EIP;
            EFLAGS_out  <= wb_EFLAGS;
            CS_out      <= wb_CS;
          end
        end
        S_PULSE: begin
          IE_out <= 1'b0;
          cnt    <= 4'd0;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          if (is_servicing_IE) begin
            state <= S_BUSY;
          end else if (cnt == TO_LAST) begin
            start_err <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_BUSY: begin
          if (!is_servicing_IE) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef IE_DROP_COUNT_EN
  // saturating count of faults dropped while busy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_cnt <= 8'd0;
    end else if (enable) begin
      if (fault_hit && busy
          && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ie_collector.sv
// tb_ie_collector: directed checks of issue priority,
// deferral, timeout, stall and reset behaviour.
module tb_ie_collector;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        wb_valid;
  logic        wb_prot_fault;
  logic        wb_page_fault;
  logic [31:0] wb_EIP;
  logic [31:0] wb_next_EIP;
  logic [17:0] wb_EFLAGS;
  logic [15:0] wb_CS;
  logic        int_req;
  logic        is_servicing_IE;
  logic        IE_out;
  logic [2:0]  IE_type_out;
  logic [31:0] EIP_out;
  logic [17:0] EFLAGS_out;
  logic [15:0] CS_out;
  logic        busy;
  logic        start_err;
`ifdef IE_DROP_COUNT_EN
  logic [7:0]  drop_cnt;
`endif

  int checks;
  int passes;

  ie_collector #(.START_TIMEOUT(15)) dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .wb_valid        (wb_valid),
    .wb_prot_fault   (wb_prot_fault),
    .wb_page_fault   (wb_page_fault),
    .wb_EIP          (wb_EIP),
    .wb_next_EIP     (wb_next_EIP),
    .wb_EFLAGS       (wb_EFLAGS),
    .wb_CS           (wb_CS),
    .int_req         (int_req),
    .is_servicing_IE (is_servicing_IE),
    .IE_out          (IE_out),
    .IE_type_out     (IE_type_out),
    .EIP_out         (EIP_out),
    .EFLAGS_out      (EFLAGS_out),
    .CS_out          (CS_out),
    .busy            (busy),
`ifdef IE_DROP_COUNT_EN
    .drop_cnt        (drop_cnt),
`endif
    .start_err       (start_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    wb_valid      = 1'b0;
    wb_prot_fault = 1'b0;
    wb_page_fault = 1'b0;
    int_req       = 1'b0;
  endtask

  // from PULSE: handler starts, then finishes
  task automatic service();
    tick();
    is_servicing_IE = 1'b1;
    tick();
    is_servicing_IE = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    enable = 1'b1;
    clear_in();
    is_servicing_IE = 1'b0;
    wb_EIP = '0;
    wb_next_EIP = '0;
    wb_EFLAGS = '0;
    wb_CS = '0;
    tick();
    tick();
    checks++;
    if ({IE_out, IE_type_out, EIP_out,
         EFLAGS_out, CS_out, busy,
         start_err} !== '0)
      $display("FAIL reset_outs got %0h/%0h/%0h busy=%0b err=%0b want 0",
               IE_out, IE_type_out, EIP_out,
               busy, start_err);
    else passes++;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_page_fault();
    wb_valid = 1'b1;
    wb_page_fault = 1'b1;
    wb_EIP = 32'h0000_1000;
    wb_next_EIP = 32'h0000_1004;
    wb_EFLAGS = 18'h0_0246;
    wb_CS = 16'h0010;
    tick();
    clear_in();
    checks++;
    if (IE_out !== 1'b1 || IE_type_out !== 3'b010
        || EIP_out !== 32'h1000 || busy !== 1'b1)
      $display("FAIL page_issue got ie=%0b t=%b eip=%h busy=%0b want 1/010/1000/1",
               IE_out, IE_type_out, EIP_out, busy);
    else passes++;
    tick();
    checks++;
    if (IE_out !== 1'b0 || IE_type_out !== 3'b010
        || EIP_out !== 32'h1000)
      $display("FAIL page_hold got ie=%0b t=%b eip=%h want 0/010/1000",
               IE_out, IE_type_out, EIP_out);
    else passes++;
    is_servicing_IE = 1'b1;
    tick();
    is_servicing_IE = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0)
      $display("FAIL page_done got busy=%0b want 0", busy);
    else passes++;
  endtask

  task automatic test_priority();
    wb_valid = 1'b1;
    wb_prot_fault = 1'b1;
    wb_page_fault = 1'b1;
    int_req = 1'b1;
    wb_EIP = 32'h0000_2000;
    wb_next_EIP = 32'h0000_2004;
    wb_EFLAGS = 18'h3_0202;
    wb_CS = 16'h0008;
    tick();
    clear_in();
    checks++;
    if (IE_out !== 1'b1 || IE_type_out !== 3'b001
        || EIP_out !== 32'h2000
        || EFLAGS_out !== 18'h3_0202
        || CS_out !== 16'h0008)
      $display("FAIL prio_fault got t=%b eip=%h fl=%h cs=%h want 001/2000/30202/0008",
               IE_type_out, EIP_out, EFLAGS_out, CS_out);
    else passes++;
    wb_valid = 1'b1;
    wb_page_fault = 1'b1;
    wb_EIP = 32'h0000_2100;
    tick();
    is_servicing_IE = 1'b1;
    tick();
    is_servicing_IE = 1'b0;
    tick();
    checks++;
    if (IE_out !== 1'b0 || EIP_out !== 32'h2000)
      $display("FAIL prio_drop got ie=%0b eip=%h want 0/2000",
               IE_out, EIP_out);
    else passes++;
    clear_in();
    wb_valid = 1'b1;
    wb_EIP = 32'h0000_3004;
    wb_next_EIP = 32'h0000_3008;
    tick();
    clear_in();
    checks++;
    if (IE_out !== 1'b1 || IE_type_out !== 3'b100
        || EIP_out !== 32'h3008)
      $display("FAIL prio_int got ie=%0b t=%b eip=%h want 1/100/3008",
               IE_out, IE_type_out, EIP_out);
    else passes++;
    service();
    wb_valid = 1'b1;
    tick();
    clear_in();
    checks++;
    if (IE_out !== 1'b0 || busy !== 1'b0)
      $display("FAIL int_consumed got ie=%0b busy=%0b want 0/0",
               IE_out, busy);
    else passes++;
  endtask

  task automatic test_int_deferred();
    int_req = 1'b1;
    tick();
    int_req = 1'b0;
    tick();
    tick();
    checks++;
    if (IE_out !== 1'b0)
      $display("FAIL int_wait got ie=%0b want 0", IE_out);
    else passes++;
    wb_valid = 1'b1;
    wb_next_EIP = 32'h0000_4000;
    tick();
    clear_in();
    checks++;
    if (IE_out !== 1'b1 || IE_type_out !== 3'b100
        || EIP_out !== 32'h4000)
      $display("FAIL int_late got ie=%0b t=%b eip=%h want 1/100/4000",
               IE_out, IE_type_out, EIP_out);
    else passes++;
    service();
  endtask

  task automatic test_timeout();
    wb_valid = 1'b1;
    wb_prot_fault = 1'b1;
    wb_EIP = 32'h0000_5000;
    tick();
    clear_in();
    tick();
    for (int i = 0; i < 14; i++) tick();
    checks++;
    if (start_err !== 1'b0 || busy !== 1'b1)
      $display("FAIL to_early got err=%0b busy=%0b want 0/1",
               start_err, busy);
    else passes++;
    tick();
    checks++;
    if (start_err !== 1'b1 || busy !== 1'b0)
      $display("FAIL to_fire got err=%0b busy=%0b want 1/0",
               start_err, busy);
    else passes++;
    wb_valid = 1'b1;
    wb_page_fault = 1'b1;
    wb_EIP = 32'h0000_6000;
    tick();
    clear_in();
    checks++;
    if (IE_out !== 1'b1 || EIP_out !== 32'h6000
        || start_err !== 1'b1)
      $display("FAIL to_after got ie=%0b eip=%h err=%0b want 1/6000/1",
               IE_out, EIP_out, start_err);
    else passes++;
    service();
  endtask

  task automatic test_enable_stall();
    wb_valid = 1'b1;
    wb_prot_fault = 1'b1;
    wb_EIP = 32'h0000_7000;
    tick();
    clear_in();
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (IE_out !== 1'b1)
        $display("FAIL stall_%0d got ie=%0b want 1", i, IE_out);
      else passes++;
    end
    enable = 1'b1;
    tick();
    checks++;
    if (IE_out !== 1'b0 || busy !== 1'b1)
      $display("FAIL stall_end got ie=%0b busy=%0b want 0/1",
               IE_out, busy);
    else passes++;
    is_servicing_IE = 1'b1;
    tick();
    is_servicing_IE = 1'b0;
    tick();
  endtask

  task automatic test_drop_count();
    bit saw;
    saw = 1'b0;
    wb_valid = 1'b1;
    wb_page_fault = 1'b1;
    wb_EIP = 32'h0000_8000;
    tick();
    wb_page_fault = 1'b0;
    wb_prot_fault = 1'b1;
    is_servicing_IE = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (IE_out) saw = 1'b1;
`ifdef IE_DROP_COUNT_EN
      if (i == 99) begin
        checks++;
        if (drop_cnt !== 8'd100)
          $display("FAIL drop_100 got %0d want 100", drop_cnt);
        else passes++;
      end
`endif
    end
    checks++;
    if (saw !== 1'b0 || EIP_out !== 32'h8000)
      $display("FAIL drop_none got pulse=%0b eip=%h want 0/8000",
               saw, EIP_out);
    else passes++;
`ifdef IE_DROP_COUNT_EN
    checks++;
    if (drop_cnt !== 8'd255)
      $display("FAIL drop_sat got %0d want 255", drop_cnt);
    else passes++;
`endif
    clear_in();
    is_servicing_IE = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_busy();
    wb_valid = 1'b1;
    wb_page_fault = 1'b1;
    wb_EIP = 32'h0000_9000;
    tick();
    clear_in();
    tick();
    is_servicing_IE = 1'b1;
    int_req = 1'b1;
    tick();
    int_req = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({IE_out, IE_type_out, EIP_out,
         EFLAGS_out, CS_out, busy,
         start_err} !== '0)
      $display("FAIL rst_busy got t=%b eip=%h busy=%0b err=%0b want 0",
               IE_type_out, EIP_out, busy, start_err);
    else passes++;
    tick();
    reset = 1'b1;
    is_servicing_IE = 1'b0;
    wb_valid = 1'b1;
    tick();
    checks++;
    if (IE_out !== 1'b0)
      $display("FAIL rst_int_lost got ie=%0b want 0", IE_out);
    else passes++;
    wb_page_fault = 1'b1;
    wb_EIP = 32'h0000_1000;
    tick();
    clear_in();
    checks++;
    if (IE_out !== 1'b1 || IE_type_out !== 3'b010
        || EIP_out !== 32'h1000)
      $display("FAIL rst_then_page got ie=%0b t=%b eip=%h want 1/010/1000",
               IE_out, IE_type_out, EIP_out);
    else passes++;
    service();
  endtask

  initial begin
    checks = 0;
    passes = 0;
    test_reset();
    test_page_fault();
    test_priority();
    test_int_deferred();
    test_timeout();
    test_enable_stall();
    test_drop_count();
    test_reset_mid_busy();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
